// File: rtl/color_region_manager.sv
// color_region_manager
//   Decodes a UART byte stream into per-region colour writes and split/debug
//   control. It keeps an H_REGIONS x V_REGIONS colour table and mirrors every
//   table write to a configuration sink over a valid/ready handshake. It also
//   drives the registered per-pixel VGA colour.
//
// Ports
//   Clk, rst                   clock, synchronous active-high reset
//   Empty, Rd_En, RXD_Data     FWFT RX FIFO (byte valid whenever Empty=0)
//   C_Rdy, C_Valid, C_Addr,
//   C_Data                     configuration write handshake
//   HSync, VSync, Pixel_En     line start, frame start, pixel strobe
//   Data_VGA                   pixel colour, one cycle after Pixel_En
//   Config_Status              FSM state (IDLE=0, WAIT_DATA=1, WRITE=2)
//   Config_Notification_Valid  pulse in the cycle a table write completes
//   Config_Error, Error_Valid  last error code, one-cycle error pulse
//   Split_State                {Debug, H_Split, V_Split}
module color_region_manager #(
  parameter int H_REGIONS    = 2,
  parameter int V_REGIONS    = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int C_ADDR_WIDTH = 6,
  parameter int TIMEOUT      = 1024,
  parameter int COLOR_WIDTH  = 6
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    Empty,
  output logic                    Rd_En,
  input  logic [7:0]              RXD_Data,
  input  logic                    C_Rdy,
  output logic                    C_Valid,
  output logic [C_ADDR_WIDTH-1:0] C_Addr,
  output logic [COLOR_WIDTH-1:0]  C_Data,
  input  logic                    HSync,
  input  logic                    VSync,
  input  logic                    Pixel_En,
  output logic [COLOR_WIDTH-1:0]  Data_VGA,
  output logic [1:0]              Config_Status,
  output logic                    Config_Notification_Valid,
  output logic [2:0]              Config_Error,
  output logic                    Error_Valid,
  output logic [2:0]              Split_State
);

  localparam int R  = H_REGIONS * V_REGIONS;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_DATA = 2'd1, WRITE = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic                     pop;
  logic [1:0]               kind;
  logic [5:0]               payload;
  logic                     idx_ok;
  logic                     latch_idx, latch_col, timer_clr, timer_inc;
  logic                     ctl_apply, err_fire, commit;
  logic [2:0]               err_code;
  logic [5:0]               idx_r;
  logic [COLOR_WIDTH-1:0]   col_r;
  logic [TW-1:0]            timer;
  logic                     split_v, split_h, debug;
  logic [XW-1:0]            x;
  logic [YW-1:0]            y;
  logic [COLOR_WIDTH-1:0]   color_tab [64];
  logic [5:0]               idx_p0;
  logic [COLOR_WIDTH-1:0]   pix_p0;

  // Region index of a pixel: count the column/row boundaries already passed.
  // Columns only split when V_Split is set, rows only when H_Split is set.
  function automatic logic [5:0] region_of(input logic [XW-1:0] px,
                                           input logic [YW-1:0] py,
                                           input logic hs, input logic vs);
    int col;
    int row;
    col = 0;
    row = 0;
    for (int k = 1; k < H_REGIONS; k++)
      if (vs && int'(px) >= k * H_ACTIVE / H_REGIONS) col++;
    for (int k = 1; k < V_REGIONS; k++)
      if (hs && int'(py) >= k * V_ACTIVE / V_REGIONS) row++;
    return 6'(row * H_REGIONS + col);
  endfunction

  assign pop     = !rst && !Empty && (state != WRITE);
  assign kind    = RXD_Data[7:6];
  assign payload = RXD_Data[5:0];
  assign idx_ok  = (int'(payload) < R);

  always_ff @(posedge Clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_idx = 1'b0;
    latch_col = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    ctl_apply = 1'b0;
    err_fire  = 1'b0;
    err_code  = 3'd0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          case (kind)
            2'b00: begin
              if (idx_ok) begin
                latch_idx = 1'b1;
                timer_clr = 1'b1;
                state_nxt = WAIT_DATA;
              end else begin
                err_fire = 1'b1;
                err_code = 3'd3;
              end
            end
            2'b01:   begin err_fire = 1'b1; err_code = 3'd1; end
            2'b10:   begin err_fire = 1'b1; err_code = 3'd5; end
            default: ctl_apply = 1'b1;
          endcase
        end
      end
      WAIT_DATA: begin
        if (pop && kind == 2'b01) begin
          latch_col = 1'b1;
          state_nxt = WRITE;
        end else if (pop && kind == 2'b00) begin
          // Missing data byte: report it, then treat the byte as a fresh header.
          err_fire = 1'b1;
          err_code = 3'd2;
          if (idx_ok) begin
            latch_idx = 1'b1;
            timer_clr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (pop && kind == 2'b10) begin
          err_fire  = 1'b1;
          err_code  = 3'd5;
          state_nxt = IDLE;
        end else begin
          // Control bytes do not restart the data-byte timer.
          ctl_apply = pop;
          if (timer == TW'(TIMEOUT - 1)) begin
            err_fire  = 1'b1;
            err_code  = 3'd4;
            state_nxt = IDLE;
          end else begin
            timer_inc = 1'b1;
          end
        end
      end
      WRITE: begin
        if (C_Rdy) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Rd_En                     = pop;
    C_Valid                   = (state == WRITE);
    C_Addr                    = C_ADDR_WIDTH'(idx_r);
    C_Data                    = col_r;
    Config_Status             = state;
    Config_Notification_Valid = (state == WRITE) && C_Rdy && !rst;
  end

  // Stage p0: region lookup from the current pixel counters
  always_comb begin
    idx_p0 = region_of(x, y, split_h, split_v);
    if (x >= XW'(H_ACTIVE) || y >= YW'(V_ACTIVE)) pix_p0 = '0;
    else if (debug)                                pix_p0 = COLOR_WIDTH'(idx_p0);
    else                                           pix_p0 = color_tab[idx_p0];
  end

  // Stage p1: registered state, table and pixel colour
  always_ff @(posedge Clk) begin
    if (rst) begin
      idx_r        <= '0;
      col_r        <= '0;
      timer        <= '0;
      split_v      <= 1'b0;
      split_h      <= 1'b0;
      debug        <= 1'b0;
      Config_Error <= 3'd0;
      Error_Valid  <= 1'b0;
      x            <= '0;
      y            <= '0;
      Data_VGA     <= '0;
      for (int i = 0; i < 64; i++) color_tab[i] <= '0;
    end else begin
      Error_Valid <= err_fire;
      if (err_fire)  Config_Error <= err_code;
      if (latch_idx) idx_r <= payload;
      if (latch_col) col_r <= COLOR_WIDTH'(payload);
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (ctl_apply) {debug, split_h, split_v} <= payload[2:0];
      if (commit) color_tab[idx_r] <= col_r;
      if (HSync)                     x <= '0;
      else if (Pixel_En && x != '1) x <= x + 1'b1;
      if (VSync)                     y <= '0;
      else if (HSync && y != '1)    y <= y + 1'b1;
      if (Pixel_En) Data_VGA <= pix_p0;
    end
  end

  assign Split_State = {debug, split_h, split_v};

endmodule

// File: tb/tb_color_region_manager.sv
// Testbench for color_region_manager: byte-level stimulus, a scoreboard for
// configuration writes and per-pixel colours, and a small reference model.
module tb_color_region_manager;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int H_REGIONS = 2;
  localparam int V_REGIONS = 2;
  localparam int TIMEOUT   = 1024;

  logic       Clk = 1'b0;
  logic       rst, Empty, Rd_En;
  logic [7:0] RXD_Data;
  logic       C_Rdy, C_Valid;
  logic [5:0] C_Addr, C_Data;
  logic       HSync, VSync, Pixel_En;
  logic [5:0] Data_VGA;
  logic [1:0] Config_Status;
  logic       Config_Notification_Valid;
  logic [2:0] Config_Error;
  logic       Error_Valid;
  logic [2:0] Split_State;

  color_region_manager dut (
    .Clk(Clk), .rst(rst), .Empty(Empty), .Rd_En(Rd_En), .RXD_Data(RXD_Data),
    .C_Rdy(C_Rdy), .C_Valid(C_Valid), .C_Addr(C_Addr), .C_Data(C_Data),
    .HSync(HSync), .VSync(VSync), .Pixel_En(Pixel_En), .Data_VGA(Data_VGA),
    .Config_Status(Config_Status),
    .Config_Notification_Valid(Config_Notification_Valid),
    .Config_Error(Config_Error), .Error_Valid(Error_Valid),
    .Split_State(Split_State)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [11:0] wr_q[$];
  logic [5:0]  pix_q[$];
  logic [5:0]  m_tab[4];
  logic        m_dbg, m_hs, m_vs;
  int          mx, my;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [5:0] exp_pix(int px, int py);
    int c, r;
    if (px >= H_ACTIVE || py >= V_ACTIVE) return '0;
    c = m_vs ? (px * H_REGIONS) / H_ACTIVE : 0;
    r = m_hs ? (py * V_REGIONS) / V_ACTIVE : 0;
    if (m_dbg) return 6'(r * H_REGIONS + c);
    return m_tab[r * H_REGIONS + c];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    Empty = 1'b0;
    RXD_Data = b;
    #1;
    while (!Rd_En && w < 8) begin tick(); w++; end
    if (!Rd_En) begin
      n_vec++; n_bad++;
      $display("FAIL pop_wait byte=%h: Rd_En got 0 want 1", b);
    end
    tick();
    Empty = 1'b1;
  endtask

  task automatic set_ctl(input logic [2:0] c);
    send_byte({5'b11000, c});
    {m_dbg, m_hs, m_vs} = c;
    n_vec++;
    if (Split_State !== c) begin n_bad++; $display("FAIL split_state got %b want %b", Split_State, c); end
  endtask

  // Data byte for an already-latched header, with C_Rdy high.
  task automatic finish_write(input logic [5:0] idx, input logic [5:0] col);
    logic [11:0] e;
    wr_q.push_back({idx, col});
    send_byte({2'b01, col});
    n_vec++;
    if (!(C_Valid && Config_Notification_Valid)) begin
      n_bad++;
      $display("FAIL wr_handshake got v=%b n=%b want v=1 n=1", C_Valid, Config_Notification_Valid);
    end
    e = wr_q.pop_front();
    n_vec++;
    if ({C_Addr, C_Data} !== e) begin n_bad++; $display("FAIL wr_addr_data got %h want %h", {C_Addr, C_Data}, e); end
    m_tab[idx[1:0]] = col;
    tick();
    n_vec++;
    if (C_Valid !== 1'b0) begin n_bad++; $display("FAIL wr_valid_drop got %b want 0", C_Valid); end
  endtask

  task automatic do_write(input logic [5:0] idx, input logic [5:0] col);
    send_byte({2'b00, idx});
    finish_write(idx, col);
  endtask

  task automatic pixels(input int n, input string tag);
    logic [5:0] e;
    int px;
    for (int i = 0; i < n; i++) begin
      px = mx;
      pix_q.push_back(exp_pix(mx, my));
      Pixel_En = 1'b1;
      tick();
      if (mx < 1023) mx++;
      e = pix_q.pop_front();
      n_vec++;
      if (Data_VGA !== e) begin
        n_bad++;
        $display("FAIL %s x=%0d y=%0d got %h want %h", tag, px, my, Data_VGA, e);
      end
    end
    Pixel_En = 1'b0;
  endtask

  task automatic hsync();
    HSync = 1'b1; tick(); HSync = 1'b0;
    mx = 0;
    if (my < 1023) my++;
  endtask

  task automatic frame_start();
    VSync = 1'b1; HSync = 1'b1; tick(); VSync = 1'b0; HSync = 1'b0;
    mx = 0; my = 0;
  endtask

  task automatic goto_line(input int t);
    while (my < t) hsync();
  endtask

  task automatic scan_frame(input string tag);
    frame_start();
    pixels(660, tag);
    goto_line(V_ACTIVE / 2 - 1);
    pixels(660, tag);
    hsync();
    pixels(660, tag);
    goto_line(V_ACTIVE);
    pixels(8, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; Empty = 1'b1; RXD_Data = 8'h00; C_Rdy = 1'b0;
    HSync = 1'b0; VSync = 1'b0; Pixel_En = 1'b0;
    tick(); tick();
    n_vec++;
    if ({Rd_En, C_Valid, C_Addr, C_Data, Data_VGA, Config_Status, Config_Notification_Valid,
         Config_Error, Error_Valid, Split_State} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b st=%0d err=%0d ev=%b split=%b vga=%h want all 0",
               C_Valid, Config_Status, Config_Error, Error_Valid, Split_State, Data_VGA);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_tab[i] = '0;
    m_dbg = 0; m_hs = 0; m_vs = 0; mx = 0; my = 0;
    pixels(4, "reset_pix");
  endtask

  task automatic test_region_write();
    logic [11:0] e;
    int cnt;
    cnt = 0;
    C_Rdy = 1'b0;
    wr_q.push_back({6'd3, 6'h1A});
    send_byte(8'h03);
    send_byte(8'h5A);
    Empty = 1'b0; RXD_Data = 8'hC7;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (C_Valid) cnt++;
      n_vec++;
      if ({C_Valid, Rd_En, Config_Notification_Valid, C_Addr, C_Data} !== {3'b100, 6'd3, 6'h1A}) begin
        n_bad++;
        $display("FAIL wr_hold cyc=%0d got v=%b rd=%b n=%b a=%0d d=%h want v=1 rd=0 n=0 a=3 d=1a",
                 i, C_Valid, Rd_En, Config_Notification_Valid, C_Addr, C_Data);
      end
      tick();
    end
    C_Rdy = 1'b1; Empty = 1'b1;
    #1;
    if (C_Valid) cnt++;
    n_vec++;
    if (Config_Notification_Valid !== 1'b1) begin n_bad++; $display("FAIL wr_notify got %b want 1", Config_Notification_Valid); end
    e = wr_q.pop_front();
    n_vec++;
    if ({C_Addr, C_Data} !== e) begin n_bad++; $display("FAIL wr_data got %h want %h", {C_Addr, C_Data}, e); end
    m_tab[3] = 6'h1A;
    tick();
    n_vec++;
    if ({C_Valid, Config_Notification_Valid, Config_Status} !== 4'b0) begin
      n_bad++;
      $display("FAIL wr_end got v=%b n=%b st=%0d want 0 0 0", C_Valid, Config_Notification_Valid, Config_Status);
    end
    n_vec++;
    if (cnt !== 6) begin n_bad++; $display("FAIL wr_valid_cycles got %0d want 6", cnt); end
    set_ctl(3'b011);
    frame_start();
    goto_line(V_ACTIVE / 2);
    pixels(330, "tab3_pix");
  endtask

  task automatic test_grid();
    do_write(6'd0, 6'h01);
    do_write(6'd1, 6'h02);
    do_write(6'd2, 6'h03);
    do_write(6'd3, 6'h04);
    set_ctl(3'b011);
    scan_frame("grid_pix");
  endtask

  task automatic test_split_debug();
    set_ctl(3'b000);
    scan_frame("nosplit_pix");
    set_ctl(3'b111);
    scan_frame("debug_pix");
  endtask

  task automatic test_errors();
    logic [7:0] bytes [3];
    logic [2:0] codes [3];
    bytes = '{8'h45, 8'h3F, 8'h80};
    codes = '{3'd1, 3'd3, 3'd5};
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i]);
      n_vec++;
      if ({Error_Valid, Config_Error, Config_Status} !== {1'b1, codes[i], 2'd0}) begin
        n_bad++;
        $display("FAIL err_byte_%h got ev=%b code=%0d st=%0d want 1 %0d 0",
                 bytes[i], Error_Valid, Config_Error, Config_Status, codes[i]);
      end
      tick();
      n_vec++;
      if ({Error_Valid, Config_Error} !== {1'b0, codes[i]}) begin
        n_bad++;
        $display("FAIL err_pulse_%h got ev=%b code=%0d want 0 %0d", bytes[i], Error_Valid, Config_Error, codes[i]);
      end
    end
    send_byte(8'h01);
    send_byte(8'h02);
    n_vec++;
    if ({Error_Valid, Config_Error, Config_Status} !== {1'b1, 3'd2, 2'd1}) begin
      n_bad++;
      $display("FAIL err_hdr_hdr got ev=%b code=%0d st=%0d want 1 2 1", Error_Valid, Config_Error, Config_Status);
    end
    finish_write(6'd2, 6'h01);
  endtask

  task automatic test_timeout();
    int i;
    send_byte(8'h01);
    n_vec++;
    if (Config_Status !== 2'd1) begin n_bad++; $display("FAIL to_wait got %0d want 1", Config_Status); end
    i = 0;
    while (!Error_Valid && i < TIMEOUT + 50) begin tick(); i++; end
    n_vec++;
    if (i !== TIMEOUT) begin n_bad++; $display("FAIL to_cycles got %0d want %0d", i, TIMEOUT); end
    n_vec++;
    if ({Error_Valid, Config_Error, Config_Status} !== {1'b1, 3'd4, 2'd0}) begin
      n_bad++;
      $display("FAIL to_error got ev=%b code=%0d st=%0d want 1 4 0", Error_Valid, Config_Error, Config_Status);
    end
  endtask

  task automatic test_reset_mid_write();
    C_Rdy = 1'b0;
    send_byte(8'h02);
    send_byte(8'h55);
    n_vec++;
    if (C_Valid !== 1'b1) begin n_bad++; $display("FAIL rw_valid got %b want 1", C_Valid); end
    rst = 1'b1; C_Rdy = 1'b1;
    #1;
    n_vec++;
    if (Config_Notification_Valid !== 1'b0) begin n_bad++; $display("FAIL rw_notify got %b want 0", Config_Notification_Valid); end
    tick();
    rst = 1'b0;
    n_vec++;
    if ({C_Valid, Config_Status, Config_Error} !== 6'b0) begin
      n_bad++;
      $display("FAIL rw_after got v=%b st=%0d err=%0d want 0 0 0", C_Valid, Config_Status, Config_Error);
    end
    for (int k = 0; k < 4; k++) m_tab[k] = '0;
    m_dbg = 0; m_hs = 0; m_vs = 0; mx = 0; my = 0;
    set_ctl(3'b011);
    goto_line(V_ACTIVE / 2);
    pixels(4, "rw_tab2_pix");
    n_vec++;
    if (wr_q.size() !== 0) begin n_bad++; $display("FAIL wr_queue_left got %0d want 0", wr_q.size()); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_region_write();
    test_grid();
    test_split_debug();
    test_errors();
    test_timeout();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
